// File: rtl/sdram_init_seq_if.sv
// SDRAM pin bus plus the refresh req/ack pair between the init sequencer and the command engine.
// Latency: none (wires only).
// Backpressure: ref_req stays high until ref_ack has been seen once per pending refresh.
// Ports: ref_ack (engine -> sequencer); sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n,
//        sdr_ba, sdr_addr, sdr_dqm, sdr_init_done, ref_req (sequencer -> pins/engine).
// master = sequencer side, slave = pin/engine side.
interface sdram_init_seq_if #(
   parameter int SDR_BW = 2
);
   logic              ref_ack;
   logic              sdr_cke;
   logic              sdr_cs_n;
   logic              sdr_ras_n;
   logic              sdr_cas_n;
   logic              sdr_we_n;
   logic [1:0]        sdr_ba;
   logic [12:0]       sdr_addr;
   logic [SDR_BW-1:0] sdr_dqm;
   logic              sdr_init_done;
   logic              ref_req;

   modport master (
      input  ref_ack,
      output sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n,
      output sdr_ba, sdr_addr, sdr_dqm, sdr_init_done, ref_req
   );

   modport slave (
      output ref_ack,
      input  sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n,
      input  sdr_ba, sdr_addr, sdr_dqm, sdr_init_done, ref_req
   );
endinterface

// File: rtl/sdram_init_seq.sv
// SDR SDRAM power-up sequencer (CKE wait, PRECHARGE ALL, N x AUTO REFRESH, LOAD MODE) and refresh-interval timer.
// Latency: all outputs registered; each command lasts one cycle and the next follows tX cycles later.
// Backpressure: refresh requests accumulate in a 4-bit saturating counter until acknowledged.
// Ports: sdram_clk, sdram_resetn (sync, active-low); bus = sdram_init_seq_if.master (pins, init_done, ref_req/ref_ack).
// Option: define SDR_INIT_EMRS_EN to issue an extended mode register load (ba=2'b10, EMR_VAL) after the LMR.
module sdram_init_seq #(
   parameter int          SDR_DW       = 16,
   parameter int          SDR_BW       = 2,
   parameter int          PWR_CYC      = 20000,
   parameter int          TRP          = 2,
   parameter int          TRFC         = 7,
   parameter int          TMRD         = 2,
   parameter int          NUM_REF      = 8,
   parameter logic [12:0] MODE_REG     = 13'h033,
   parameter logic [12:0] EMR_VAL      = 13'h000,
   parameter int          REF_INTERVAL = 780
) (
   input  logic                 sdram_clk,
   input  logic                 sdram_resetn,
   sdram_init_seq_if.master     bus
);
   localparam int MAX_A = (PWR_CYC > REF_INTERVAL) ? PWR_CYC : REF_INTERVAL;
   localparam int MAX_C = (MAX_A > TRFC) ? MAX_A : TRFC;
   localparam int CW    = $clog2(MAX_C) + 1;
   localparam int RW    = $clog2(NUM_REF + 1);

   // {cs_n, ras_n, cas_n, we_n}
   localparam logic [3:0] CMD_NOP = 4'b0111;
   localparam logic [3:0] CMD_PRE = 4'b0010;
   localparam logic [3:0] CMD_REF = 4'b0001;
   localparam logic [3:0] CMD_LMR = 4'b0000;

   if (SDR_DW != 8 * SDR_BW || PWR_CYC < 1 || TRP < 1 || TRFC < 1 || TMRD < 1 ||
       NUM_REF < 1 || REF_INTERVAL < 1) begin : g_param_check
      $error("sdram_init_seq: illegal parameter set");
   end

   typedef enum logic [3:0] {
      WAIT_PWR, CKE_NOP, PRE, WAIT_TRP, REF, WAIT_TRFC,
      LMR, WAIT_TMRD, EMRS, WAIT_EMRS, DONE
   } state_t;

   state_t            state, nstate, after_ref, after_lmr;
   logic [CW-1:0]     cnt, ncnt;
   logic [RW-1:0]     ref_cnt, nref_cnt;
   logic [3:0]        ref_pend, npend;
   logic              wrap, ack_hit;
   logic              n_cke, n_done, n_req;
   logic [3:0]        n_cmd;
   logic [1:0]        n_ba;
   logic [12:0]       n_addr;
   logic [SDR_BW-1:0] n_dqm;

   // ref_cnt already includes the REF being issued when this is consulted.
   assign after_ref = (ref_cnt == RW'(NUM_REF)) ? LMR : REF;
`ifdef SDR_INIT_EMRS_EN
   assign after_lmr = EMRS;
`else
   assign after_lmr = DONE;
`endif

   always_comb begin
      nstate   = state;
      ncnt     = cnt + 1'b1;
      nref_cnt = ref_cnt;
      wrap     = 1'b0;
      case (state)
         // The reset edge itself is not a wait cycle: cycle 0 is the first edge out of reset,
         // so cnt equals the cycle index here and we leave after PWR_CYC cycles.
         WAIT_PWR:  if (cnt == CW'(PWR_CYC)) begin nstate = CKE_NOP; ncnt = '0; end
         CKE_NOP:   begin nstate = PRE; ncnt = '0; end
         // Command states last one cycle; the WAIT_x states cover the remaining tX-1 NOPs
         // and are skipped entirely when tX is 1.
         PRE:       begin nstate = (TRP > 1) ? WAIT_TRP : REF; ncnt = '0; end
         WAIT_TRP:  if (cnt == CW'((TRP > 1) ? TRP - 2 : 0)) begin nstate = REF; ncnt = '0; end
         REF:       begin nstate = (TRFC > 1) ? WAIT_TRFC : after_ref; ncnt = '0; end
         WAIT_TRFC: if (cnt == CW'((TRFC > 1) ? TRFC - 2 : 0)) begin nstate = after_ref; ncnt = '0; end
         LMR:       begin nstate = (TMRD > 1) ? WAIT_TMRD : after_lmr; ncnt = '0; end
         WAIT_TMRD: if (cnt == CW'((TMRD > 1) ? TMRD - 2 : 0)) begin nstate = after_lmr; ncnt = '0; end
         EMRS:      begin nstate = (TMRD > 1) ? WAIT_EMRS : DONE; ncnt = '0; end
         WAIT_EMRS: if (cnt == CW'((TMRD > 1) ? TMRD - 2 : 0)) begin nstate = DONE; ncnt = '0; end
         // cnt doubles as the refresh interval timer once init is complete.
         DONE:      if (cnt == CW'(REF_INTERVAL - 1)) begin wrap = 1'b1; ncnt = '0; end
         default:   begin nstate = WAIT_PWR; ncnt = '0; end
      endcase

      if (nstate == REF) nref_cnt = ref_cnt + 1'b1;

      // Wrap and ack together cancel out; ack with nothing pending is ignored.
      ack_hit = (state == DONE) && bus.ref_ack && (ref_pend != 4'd0);
      npend   = ref_pend;
      if (wrap && !ack_hit && ref_pend != 4'hF) npend = ref_pend + 4'd1;
      else if (ack_hit && !wrap)                npend = ref_pend - 4'd1;
      n_req = (npend != 4'd0);

      // Pin values are decoded from the state being entered so they line up with it after the edge.
      n_cke  = 1'b1;
      n_cmd  = CMD_NOP;
      n_ba   = 2'b00;
      n_addr = 13'h0000;
      n_dqm  = '1;
      n_done = 1'b0;
      case (nstate)
         WAIT_PWR: n_cke = 1'b0;
         PRE:      begin n_cmd = CMD_PRE; n_addr = 13'h0400; end
         REF:      n_cmd = CMD_REF;
         LMR:      begin n_cmd = CMD_LMR; n_addr = MODE_REG; end
         EMRS:     begin n_cmd = CMD_LMR; n_ba = 2'b10; n_addr = EMR_VAL; end
         DONE:     begin n_dqm = '0; n_done = 1'b1; end
         default:  ;
      endcase
   end

   always_ff @(posedge sdram_clk) begin
      if (!sdram_resetn) begin
         state             <= WAIT_PWR;
         cnt               <= '0;
         ref_cnt           <= '0;
         ref_pend          <= '0;
         bus.sdr_cke       <= 1'b0;
         {bus.sdr_cs_n, bus.sdr_ras_n, bus.sdr_cas_n, bus.sdr_we_n} <= CMD_NOP;
         bus.sdr_ba        <= 2'b00;
         bus.sdr_addr      <= 13'h0000;
         bus.sdr_dqm       <= '1;
         bus.sdr_init_done <= 1'b0;
         bus.ref_req       <= 1'b0;
      end else begin
         state             <= nstate;
         cnt               <= ncnt;
         ref_cnt           <= nref_cnt;
         ref_pend          <= npend;
         bus.sdr_cke       <= n_cke;
         {bus.sdr_cs_n, bus.sdr_ras_n, bus.sdr_cas_n, bus.sdr_we_n} <= n_cmd;
         bus.sdr_ba        <= n_ba;
         bus.sdr_addr      <= n_addr;
         bus.sdr_dqm       <= n_dqm;
         bus.sdr_init_done <= n_done;
         bus.ref_req       <= n_req;
      end
   end
endmodule

// File: tb/tb_sdram_init_seq.sv
// Bench for sdram_init_seq with the small timing set (PWR_CYC=10, TRP=2, TRFC=3, NUM_REF=2, TMRD=2, REF_INTERVAL=5).
// Every cycle the expected pin/flag state is pushed to a queue as stimulus is applied and popped after the edge.
// Works with or without SDR_INIT_EMRS_EN defined.
module tb_sdram_init_seq;
   typedef struct packed {
      logic        cke;
      logic [3:0]  cmd;
      logic [1:0]  ba;
      logic [12:0] addr;
      logic [1:0]  dqm;
      logic        done;
      logic        req;
   } obs_t;

   localparam logic [3:0] C_NOP = 4'b0111;
   localparam logic [3:0] C_PRE = 4'b0010;
   localparam logic [3:0] C_REF = 4'b0001;
   localparam logic [3:0] C_LMR = 4'b0000;
`ifdef SDR_INIT_EMRS_EN
   localparam int DONE_CYC = 23;
`else
   localparam int DONE_CYC = 21;
`endif
   localparam obs_t RST_OBS = '{cke: 1'b0, cmd: C_NOP, ba: 2'b00, addr: 13'h0000,
                                dqm: 2'b11, done: 1'b0, req: 1'b0};

   logic clk = 1'b0;
   logic resetn = 1'b0;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   m_pend = 0;
   obs_t exp_q[$];

   always #5 clk = ~clk;

   sdram_init_seq_if #(.SDR_BW(2)) bus ();

   sdram_init_seq #(
      .SDR_DW(16), .SDR_BW(2), .PWR_CYC(10), .TRP(2), .TRFC(3), .TMRD(2), .NUM_REF(2),
      .MODE_REG(13'h033), .EMR_VAL(13'h000), .REF_INTERVAL(5)
   ) dut (
      .sdram_clk    (clk),
      .sdram_resetn (resetn),
      .bus          (bus)
   );

   function automatic obs_t observe();
      obs_t o;
      o.cke  = bus.sdr_cke;
      o.cmd  = {bus.sdr_cs_n, bus.sdr_ras_n, bus.sdr_cas_n, bus.sdr_we_n};
      o.ba   = bus.sdr_ba;
      o.addr = bus.sdr_addr;
      o.dqm  = bus.sdr_dqm;
      o.done = bus.sdr_init_done;
      o.req  = bus.ref_req;
      return o;
   endfunction

   // Expected outputs after edge c of a run, straight from the power-up timeline.
   function automatic obs_t exp_at(int c, int pend);
      obs_t e;
      e.cke  = (c >= 10);
      e.cmd  = C_NOP;
      e.ba   = 2'b00;
      e.addr = 13'h0000;
      e.dqm  = 2'b11;
      e.done = 1'b0;
      e.req  = (pend != 0);
      if (c == 11) begin e.cmd = C_PRE; e.addr = 13'h0400; end
      if (c == 13 || c == 16) e.cmd = C_REF;
      if (c == 19) begin e.cmd = C_LMR; e.addr = 13'h0033; end
`ifdef SDR_INIT_EMRS_EN
      if (c == 21) begin e.cmd = C_LMR; e.ba = 2'b10; e.addr = 13'h0000; end
`endif
      if (c >= DONE_CYC) begin e.dqm = 2'b00; e.done = 1'b1; end
      return e;
   endfunction

   // Apply inputs for the next edge, queue what that edge should produce, and advance past it.
   task automatic drive(input logic rstn, input logic ack);
      logic wrap, hit;
      resetn      = rstn;
      bus.ref_ack = ack;
      if (!rstn) begin
         m_pend = 0;
         exp_q.push_back(RST_OBS);
      end else begin
         if (cyc > DONE_CYC) begin
            wrap   = ((cyc - DONE_CYC) % 5 == 0);
            hit    = ack && (m_pend != 0);
            m_pend = m_pend + (wrap ? 1 : 0) - (hit ? 1 : 0);
            if (m_pend > 15) m_pend = 15;
         end
         exp_q.push_back(exp_at(cyc, m_pend));
      end
      @(posedge clk);
      #1;
      cyc = rstn ? cyc + 1 : 0;
   endtask

   task automatic test_reset();
      obs_t got, want;
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b0);
         got = observe(); want = exp_q.pop_front(); total++;
         if (got !== want) begin
            bad++;
            $display("FAIL reset hold=%0d got=%h want=%h", i, got, want);
         end
      end
   endtask

   task automatic test_init_seq();
      obs_t got, want;
      while (cyc <= DONE_CYC + 1) begin
         drive(1'b1, 1'b0);
         got = observe(); want = exp_q.pop_front(); total++;
         if (got !== want) begin
            bad++;
            $display("FAIL init_seq cyc=%0d got=%h want=%h", cyc - 1, got, want);
         end
      end
   endtask

   // Ack held low: pending count climbs to 3 over three intervals.
   task automatic test_ref_accumulate();
      obs_t got, want;
      while (cyc <= DONE_CYC + 15) begin
         drive(1'b1, 1'b0);
         got = observe(); want = exp_q.pop_front(); total++;
         if (got !== want) begin
            bad++;
            $display("FAIL ref_accumulate cyc=%0d got=%h want=%h", cyc - 1, got, want);
         end
      end
   endtask

   // Four back-to-back single-cycle acks: three drain the count, the fourth must be ignored.
   task automatic test_ack_drain();
      obs_t got, want;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, (i < 4) ? 1'b1 : 1'b0);
         got = observe(); want = exp_q.pop_front(); total++;
         if (got !== want) begin
            bad++;
            $display("FAIL ack_drain cyc=%0d got=%h want=%h", cyc - 1, got, want);
         end
      end
   endtask

   // Ack on the wrap edge with one pending leaves it at one; the following ack clears it.
   task automatic test_wrap_ack();
      obs_t got, want;
      while (cyc <= DONE_CYC + 27) begin
         drive(1'b1, (cyc == DONE_CYC + 25 || cyc == DONE_CYC + 26) ? 1'b1 : 1'b0);
         got = observe(); want = exp_q.pop_front(); total++;
         if (got !== want) begin
            bad++;
            $display("FAIL wrap_ack cyc=%0d got=%h want=%h", cyc - 1, got, want);
         end
      end
   endtask

   // 100 idle cycles saturate the count at 15; a long ack run then shows exactly 15 drain.
   task automatic test_saturate();
      obs_t got, want;
      for (int i = 0; i < 128; i++) begin
         drive(1'b1, (i >= 100 && i < 122) ? 1'b1 : 1'b0);
         got = observe(); want = exp_q.pop_front(); total++;
         if (got !== want) begin
            bad++;
            $display("FAIL saturate cyc=%0d got=%h want=%h", cyc - 1, got, want);
         end
      end
   endtask

   // Reset lands at cycle 14 during the refresh phase, held 2 cycles, then a full restart.
   task automatic test_reset_mid();
      obs_t got, want;
      int   phase;
      drive(1'b0, 1'b0);
      got = observe(); want = exp_q.pop_front(); total++;
      if (got !== want) begin
         bad++;
         $display("FAIL reset_mid pre got=%h want=%h", got, want);
      end
      for (int i = 0; i < 14 + 2 + DONE_CYC + 3; i++) begin
         phase = i;
         drive((i == 14 || i == 15) ? 1'b0 : 1'b1, 1'b0);
         got = observe(); want = exp_q.pop_front(); total++;
         if (got !== want) begin
            bad++;
            $display("FAIL reset_mid step=%0d got=%h want=%h", phase, got, want);
         end
      end
   endtask

   initial begin
      bus.ref_ack = 1'b0;
      test_reset();
      test_init_seq();
      test_ref_accumulate();
      test_ack_drain();
      test_wrap_ack();
      test_saturate();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/sdram_init_seq.md
# sdram_init_seq

Power-up initialisation sequencer and refresh-interval timer for the SDR SDRAM controller. Drives the SDRAM command/address pins through the JEDEC power-up sequence: CKE-low wait, PRECHARGE ALL, N × AUTO REFRESH, LOAD MODE REGISTER. It then raises `sdr_init_done` and hands the pin bus to the downstream command engine. After init it keeps a refresh timer and requests refreshes from that engine over a req/ack handshake. Sits directly upstream of the SDRAM pin interface and owns it until `sdr_init_done`.

## Interface
Parameters:
- `SDR_DW`, 16, SDRAM data width (informational; no data path here)
- `SDR_BW`, 2, number of byte-mask bits
- `PWR_CYC`, 20000, CKE-low power-up wait in clocks (≥1)
- `TRP`, 2, precharge-to-next-command spacing in clocks (≥1)
- `TRFC`, 7, refresh-to-next-command spacing in clocks (≥1)
- `TMRD`, 2, mode-load-to-next-command spacing in clocks (≥1)
- `NUM_REF`, 8, AUTO REFRESH commands issued during init (≥1)
- `MODE_REG`, 13'h033, value driven on `sdr_addr` during LOAD MODE (CL3, BL8, sequential)
- `EMR_VAL`, 13'h000, extended mode value (used only with `SDR_INIT_EMRS_EN`)
- `REF_INTERVAL`, 780, clocks between refresh requests (≥1)

Ports:
- `sdram_clk` in 1: the single clock
- `sdram_resetn` in 1: reset, synchronous, active-low
- `ref_ack` in 1: downstream has accepted one refresh request
- `sdr_cke` out 1: clock enable
- `sdr_cs_n`, `sdr_ras_n`, `sdr_cas_n`, `sdr_we_n` out 1 each: command
- `sdr_ba` out 2: bank address
- `sdr_addr` out 13: row/mode address
- `sdr_dqm` out SDR_BW: byte masks
- `sdr_init_done` out 1: init complete, sticky until reset
- `ref_req` out 1: one or more refreshes pending

## Operation
- Commands {cs,ras,cas,we}: NOP 0111, PRE 0010, REF 0001, LMR 0000. All outputs are registered.
- Reset values: cke 0, cs/ras/cas/we 1, ba 0, addr 0, dqm all 1, init_done 0, ref_req 0. Internal counters and state are cleared.
- States:
  - WAIT_PWR: NOP with cke=0 for PWR_CYC cycles.
  - CKE_NOP: cke=1, one NOP cycle.
  - PRE: one cycle, addr[10]=1 (all banks), other addr bits 0. Then WAIT_TRP for TRP-1 NOPs.
  - REF: one cycle. Then WAIT_TRFC for TRFC-1 NOPs. Repeats until NUM_REF refreshes have been issued.
  - LMR: one cycle, ba=0, addr=MODE_REG. Then WAIT_TMRD for TMRD-1 NOPs.
  - DONE: init_done=1. Outputs hold NOP, cke=1, dqm=0, ba=0, addr=0. The downstream mux selects its own commands whenever init_done=1.
- Rule: a command occupies exactly one cycle, and the next command is issued exactly tX cycles later.
- Refresh accounting (DONE only):
  - 4-bit pending counter `ref_pend`; `ref_req` = (ref_pend≠0).
  - Interval timer starts at 0 on DONE entry and wraps every REF_INTERVAL cycles. Each wrap increments ref_pend.
  - `ref_ack` sampled high while ref_pend≠0 decrements it. An ack while ref_pend=0 is ignored.
  - Wrap and ack in the same cycle: ref_pend is unchanged.
  - ref_pend saturates at 15; further wraps are dropped.
- Reset mid-operation: sampled low `sdram_resetn` returns all outputs to reset values on that edge. Release restarts the full sequence from WAIT_PWR; no partial resume.
- Counter width: $clog2 of the largest of PWR_CYC, REF_INTERVAL, TRFC, plus 1.

## Timing
- Cycle 0 is the first edge with `sdram_resetn`=1.
- Cycles 0..PWR_CYC-1: WAIT_PWR.
- Cycle PWR_CYC: CKE_NOP.
- Cycle PWR_CYC+1: PRE.
- First REF at PWR_CYC+1+TRP. Each subsequent REF follows TRFC cycles after the previous one.
- LMR at last REF + TRFC.
- `sdr_init_done` rises TMRD cycles after LMR.
- First `ref_req` rises REF_INTERVAL cycles after `sdr_init_done` rises.
- `ref_req` falls the cycle after the ack that brings ref_pend to 0.

## Configuration
- `SDR_INIT_EMRS_EN` defined: after WAIT_TMRD, issue one extra LMR with ba=2'b10, addr=EMR_VAL, followed by TMRD-1 NOPs. Only then enter DONE. init_done is delayed by TMRD cycles.
- Undefined: no EMRS; WAIT_TMRD goes directly to DONE; EMR_VAL is unused.

## Test plan
All scenarios use PWR_CYC=10, TRP=2, TRFC=3, NUM_REF=2, TMRD=2, REF_INTERVAL=5.
- Reset held 5 cycles, then released -> at every cycle of the hold: cke 0, cmd NOP, dqm 2'b11, init_done 0, ref_req 0.
- Release reset, macro undefined -> sequence:
  - cycles 0–9: cke 0.
  - cycle 10: cke 1, NOP.
  - cycle 11: PRE with addr=13'h400.
  - cycles 13, 16: REF.
  - cycle 19: LMR with addr=13'h033, ba 0.
  - cycle 21: init_done=1; all other cycles NOP.
- Same with `SDR_INIT_EMRS_EN` -> EMRS at cycle 21 (ba 2'b10, addr 13'h000); init_done at cycle 23.
- Macro undefined, ref_ack held low -> ref_req rises at cycle 26; pend reaches 3 by cycle 36. Then three single-cycle acks -> ref_req falls after the third ack. A fourth ack changes nothing.
- Wrap coincident with ack while pend=1 -> pend stays 1, ref_req stays high. Ack low for 100 cycles -> pend saturates at 15.
- Reset asserted at cycle 14 (mid-refresh), released 2 cycles later -> outputs return to reset values. Sequence restarts from WAIT_PWR and init_done first rises 21 cycles after the new release.
